// File: rtl/instruction_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_if
// Groups the instruction-memory request bus and the IF->ID handoff of the
// fetch queue into one bundle.
//   master : the fetch queue. It drives IMEM_READ, IMEM_ADDRESS, VALID,
//            INSTRUCTION and PC. It receives IMEM_READDATA, IMEM_BUSYWAIT,
//            STALL, FLUSH and BRANCH_TARGET.
//   slave  : the environment, which is memory plus the ID/EX stages.
// ---------------------------------------------------------------------------
interface instruction_fetch_queue_if;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] BRANCH_TARGET;
    logic        VALID;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;

    modport master (
        output IMEM_READ, IMEM_ADDRESS, VALID, INSTRUCTION, PC,
        input  IMEM_READDATA, IMEM_BUSYWAIT, STALL, FLUSH, BRANCH_TARGET
    );

    modport slave (
        input  IMEM_READ, IMEM_ADDRESS, VALID, INSTRUCTION, PC,
        output IMEM_READDATA, IMEM_BUSYWAIT, STALL, FLUSH, BRANCH_TARGET
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
// IF stage. It issues instruction-memory reads and buffers the returned
// words, together with their PCs, in a DEPTH-entry FIFO. It presents one
// {INSTRUCTION, PC} pair per cycle to ID.
// Ports:
//   CLK   : clock. All state changes on the rising edge.
//   RESET : synchronous, active-high reset.
//   bus   : instruction_fetch_queue_if.master
//           - IMEM_READ / IMEM_ADDRESS / IMEM_READDATA / IMEM_BUSYWAIT
//           - STALL / FLUSH / BRANCH_TARGET
//           - VALID / INSTRUCTION / PC
// ---------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    instruction_fetch_queue_if.master bus
);
    localparam int unsigned    PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0]    ALIGN_MASK = 32'hFFFF_FFFC;

    // DRAIN waits out a request that was abandoned while memory was busy,
    // so the memory never sees an address change mid-access.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_next;
    logic [31:0]      r_drain_target;
    logic [31:0]      w_drain_target_next;
    logic [31:0]      r_fifo_instr [DEPTH];
    logic [31:0]      r_fifo_pc    [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_read;
    logic             w_done;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [31:0]      w_target;

    // In DRAIN the read stays asserted so the abandoned access can finish.
    assign w_read   = (r_state == ST_DRAIN) || (r_count != FULL_COUNT);
    assign w_done   = w_read && !bus.IMEM_BUSYWAIT;
    assign w_push   = (r_state == ST_FETCH) && w_done && !bus.FLUSH;
    assign w_valid  = (r_state == ST_FETCH) && (r_count != {(PTR_W + 1){1'b0}});
    assign w_pop    = w_valid && !bus.STALL && !bus.FLUSH;
    assign w_target = bus.BRANCH_TARGET & ALIGN_MASK;

    assign bus.IMEM_READ    = w_read;
    assign bus.IMEM_ADDRESS = r_fetch_pc;
    assign bus.VALID        = w_valid;
    assign bus.INSTRUCTION  = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign bus.PC           = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0000_0000;

    // Next-state and redirect logic. FLUSH overrides normal fetch progress.
    always_comb begin
        w_state_next        = r_state;
        w_fetch_pc_next     = r_fetch_pc;
        w_drain_target_next = r_drain_target;
        case (r_state)
            ST_FETCH: begin
                if (bus.FLUSH) begin
                    if (w_read && bus.IMEM_BUSYWAIT) begin
                        w_state_next        = ST_DRAIN;
                        w_drain_target_next = w_target;
                    end else begin
                        w_fetch_pc_next = w_target;
                    end
                end else if (w_push) begin
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                end else begin
                    w_fetch_pc_next = r_fetch_pc;
                end
            end
            ST_DRAIN: begin
                // The latest redirect wins, even one that arrives on the
                // cycle the drain completes.
                if (bus.FLUSH) begin
                    w_drain_target_next = w_target;
                    if (!bus.IMEM_BUSYWAIT) begin
                        w_state_next    = ST_FETCH;
                        w_fetch_pc_next = w_target;
                    end else begin
                        w_state_next = ST_DRAIN;
                    end
                end else if (!bus.IMEM_BUSYWAIT) begin
                    w_state_next    = ST_FETCH;
                    w_fetch_pc_next = r_drain_target;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // State register, fetch PC, and the FIFO pointer and occupancy counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= ST_FETCH;
            r_fetch_pc     <= RESET_PC & ALIGN_MASK;
            r_drain_target <= RESET_PC & ALIGN_MASK;
            r_rd_ptr       <= {PTR_W{1'b0}};
            r_wr_ptr       <= {PTR_W{1'b0}};
            r_count        <= {(PTR_W + 1){1'b0}};
        end else begin
            r_state        <= w_state_next;
            r_fetch_pc     <= w_fetch_pc_next;
            r_drain_target <= w_drain_target_next;
            if (bus.FLUSH) begin
                r_rd_ptr <= {PTR_W{1'b0}};
                r_wr_ptr <= {PTR_W{1'b0}};
                r_count  <= {(PTR_W + 1){1'b0}};
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage. Each entry keeps its own PC, so the PC always pairs
    // correctly with its instruction word.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.IMEM_READDATA;
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_queue
// Directed bench. Instance A (RESET_PC=0) runs a table of per-cycle vectors
// and several hand-written sequences. Instance B (RESET_PC=FFFF_FFF8)
// exercises address wrap and reset during a busy access. The memory model
// returns address + 0x100.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_read;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic a_rst = 1'b1;
    logic b_rst = 1'b1;
    logic a_force = 1'b0;
    logic b_busy = 1'b0;
    int   a_wait = 0;
    int   a_wcnt = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];

    instruction_fetch_queue_if bus_a();
    instruction_fetch_queue_if bus_b();

    instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .CLK(clk), .RESET(a_rst), .bus(bus_a)
    );
    instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .CLK(clk), .RESET(b_rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Memory A is busy for a_wait cycles per access, or while a_force is set.
    always @(posedge clk) begin
        if (a_rst || !bus_a.IMEM_READ || !bus_a.IMEM_BUSYWAIT) a_wcnt <= 0;
        else a_wcnt <= a_wcnt + 1;
    end
    assign bus_a.IMEM_BUSYWAIT = a_force | (a_wcnt < a_wait);
    assign bus_a.IMEM_READDATA = bus_a.IMEM_ADDRESS + 32'h0000_0100;
    assign bus_b.IMEM_BUSYWAIT = b_busy;
    assign bus_b.IMEM_READDATA = bus_b.IMEM_ADDRESS + 32'h0000_0100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic rd, input logic [31:0] ad,
                           input logic ev, input logic [31:0] epc, input logic erd,
                           input logic [31:0] ead);
        chk({tag, " valid"}, {31'd0, v}, {31'd0, ev});
        chk({tag, " pc"}, pc, ev ? epc : 32'h0000_0000);
        chk({tag, " instr"}, ins, ev ? epc + 32'h0000_0100 : NOP);
        chk({tag, " read"}, {31'd0, rd}, {31'd0, erd});
        chk({tag, " addr"}, ad, ead);
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [31:0] epc,
                         input logic erd, input logic [31:0] ead);
        chk_out(tag, bus_a.VALID, bus_a.PC, bus_a.INSTRUCTION, bus_a.IMEM_READ,
                bus_a.IMEM_ADDRESS, ev, epc, erd, ead);
    endtask

    task automatic chk_b(input string tag, input logic ev, input logic [31:0] epc,
                         input logic erd, input logic [31:0] ead);
        chk_out(tag, bus_b.VALID, bus_b.PC, bus_b.INSTRUCTION, bus_b.IMEM_READ,
                bus_b.IMEM_ADDRESS, ev, epc, erd, ead);
    endtask

    task automatic add(input logic rst, input logic st, input logic fl, input logic [31:0] tg,
                       input logic ev, input logic [31:0] epc, input logic erd,
                       input logic [31:0] ead);
        vec_t v;
        v.rst = rst; v.stall = st; v.flush = fl; v.target = tg;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_read = erd; v.exp_addr = ead;
        vq.push_back(v);
    endtask

    initial begin
        logic        exp_v;
        logic        prev_busy;
        logic [31:0] prev_addr;

        bus_a.STALL = 1'b0; bus_a.FLUSH = 1'b0; bus_a.BRANCH_TARGET = 32'h0;
        bus_b.STALL = 1'b0; bus_b.FLUSH = 1'b0; bus_b.BRANCH_TARGET = 32'h0;

        // Each row holds the inputs for one posedge and the outputs expected after it.
        //   rst   st    fl    target         v     pc             rd    addr
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h0);   // reset
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,   1'b1, 32'h4);   // first word
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,   1'b1, 32'h8);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   1'b1, 32'hC);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC,   1'b1, 32'h10);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h0);   // reset again
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b1, 32'h4);   // stall x8
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b1, 32'h8);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b1, 32'hC);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 32'h10);  // full
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 32'h10);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 32'h10);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 32'h10);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 32'h10);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,   1'b1, 32'h10);  // pop only
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,   1'b1, 32'h14);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC,   1'b1, 32'h18);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10,  1'b1, 32'h1C);  // 3 entries held
        add(1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b1, 32'h200); // flush
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h204);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h208);

        foreach (vq[i]) begin
            a_rst = vq[i].rst;
            bus_a.STALL = vq[i].stall;
            bus_a.FLUSH = vq[i].flush;
            bus_a.BRANCH_TARGET = vq[i].target;
            tick();
            chk_a($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_pc,
                  vq[i].exp_read, vq[i].exp_addr);
        end
        bus_a.FLUSH = 1'b0;
        bus_a.STALL = 1'b0;

        // Three busy cycles per access: one push every four cycles, stable address.
        a_wait = 3; a_rst = 1'b1; tick(); a_rst = 1'b0;
        prev_addr = bus_a.IMEM_ADDRESS; prev_busy = bus_a.IMEM_BUSYWAIT;
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (prev_busy) chk($sformatf("t3 addr stable c%0d", c), bus_a.IMEM_ADDRESS, prev_addr);
            exp_v = (c >= 5) && (((c - 5) % 4) == 0);
            chk($sformatf("t3 valid c%0d", c), {31'd0, bus_a.VALID}, {31'd0, exp_v});
            chk($sformatf("t3 pc c%0d", c), bus_a.PC, exp_v ? 32'((c - 5) / 4 * 4) : 32'h0);
            prev_addr = bus_a.IMEM_ADDRESS; prev_busy = bus_a.IMEM_BUSYWAIT;
        end
        a_wait = 0;

        // Flush during a busy access, then a second flush while draining.
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk_a("t5 pre", 1'b1, 32'hC, 1'b1, 32'h10);
        a_force = 1'b1; bus_a.FLUSH = 1'b1; bus_a.BRANCH_TARGET = 32'h400;
        tick(); chk_a("t5 drain1", 1'b0, 32'h0, 1'b1, 32'h10);
        bus_a.BRANCH_TARGET = 32'h800;
        tick(); chk_a("t5 drain2", 1'b0, 32'h0, 1'b1, 32'h10);
        bus_a.FLUSH = 1'b0;
        tick(); chk_a("t5 drain3", 1'b0, 32'h0, 1'b1, 32'h10);
        a_force = 1'b0;
        tick(); chk_a("t5 refetch", 1'b0, 32'h0, 1'b1, 32'h800);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_a($sformatf("t5 head%0d", k), 1'b1, 32'h800 + 32'(4 * k), 1'b1, 32'h804 + 32'(4 * k));
        end

        // Wrap from the top of the address space, then reset mid-busywait.
        b_rst = 1'b1; tick(); chk_b("t6 reset", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        b_rst = 1'b0;
        tick(); chk_b("t6 w0", 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC);
        tick(); chk_b("t6 w1", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        tick(); chk_b("t6 w2", 1'b1, 32'h0, 1'b1, 32'h4);
        b_busy = 1'b1;
        tick(); chk_b("t6 busy", 1'b0, 32'h0, 1'b1, 32'h4);
        b_rst = 1'b1;
        tick(); chk_b("t6 rst busy", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        b_rst = 1'b0; b_busy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- IF-stage block. Drives instruction-memory reads and buffers fetched words in a DEPTH-entry FIFO.
- Presents one {INSTRUCTION, PC} pair per cycle to the ID stage, which contains the immediate generator, control decode and register file.
- Absorbs ID stalls and variable memory latency (BUSYWAIT protocol).
- On FLUSH, discards all buffered and in-flight work and restarts fetching at BRANCH_TARGET.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IMEM_READ  output  1  read request to instruction memory.
- IMEM_ADDRESS  output  32  word-aligned fetch address.
- IMEM_READDATA  input  32  instruction word; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_BUSYWAIT  input  1  memory busy; the request completes in the first cycle this is low while IMEM_READ=1.
- STALL  input  1  ID cannot accept the head entry this cycle.
- FLUSH  input  1  redirect from EX (branch/jump taken).
- BRANCH_TARGET  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- VALID  output  1  head entry present.
- INSTRUCTION  output  32  head instruction; 32'h0000_0013 (NOP) when VALID=0.
- PC  output  32  address of the head instruction; 0 when VALID=0.

Behaviour:
- Internal state:
  - FETCH_PC[31:0], with [1:0] always 0.
  - FIFO storing {instr, pc}.
  - rd/wr pointers and COUNT (0..DEPTH).
  - FSM {FETCH, DRAIN}.
  - DRAIN_TARGET[31:0].
- Reset (RESET=1 at posedge):
  - FETCH_PC=RESET_PC, COUNT=0, pointers=0, FSM=FETCH.
  - Outputs the following cycle: VALID=0, INSTRUCTION=NOP, PC=0, IMEM_ADDRESS=RESET_PC, IMEM_READ=1.
  - Reset mid-request abandons the request; memory must tolerate an address change.
- IMEM_READ and IMEM_ADDRESS are driven from registered state only.
  - In FETCH: IMEM_READ = (COUNT<DEPTH), IMEM_ADDRESS = FETCH_PC.
  - In DRAIN: IMEM_READ=1 and IMEM_ADDRESS is held at the abandoned address.
- IMEM_ADDRESS must stay stable for every cycle in which IMEM_BUSYWAIT=1.
- One outstanding request at a time. A request completes in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
- Completion in FETCH (no FLUSH):
  - Push {IMEM_READDATA, FETCH_PC}.
  - FETCH_PC += 4; wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Minimum latency: memory with BUSYWAIT always low gives VALID=1 in the cycle after the first posedge at which the request completes.
- Throughput is 1 instruction/cycle when there is no stall and no wait.
- Pop: in a cycle with VALID=1 and STALL=0, the head is consumed at the posedge.
  - Simultaneous push and pop leaves COUNT unchanged.
- Full: with COUNT=DEPTH, IMEM_READ=0 and no request is issued. A pop in that cycle does not enable a same-cycle push; the request resumes the next cycle.
- Empty: VALID=0; STALL is ignored.
- FLUSH at a posedge has priority over push and pop. FIFO is emptied (COUNT=0, pointers=0), then:
  - FSM=FETCH, IMEM_BUSYWAIT=0 or IMEM_READ=0: FETCH_PC=BRANCH_TARGET. Any completing response is dropped. Fetch of the target starts next cycle.
  - FSM=FETCH, IMEM_READ=1 and IMEM_BUSYWAIT=1: FSM->DRAIN, DRAIN_TARGET=BRANCH_TARGET.
  - FSM=DRAIN: DRAIN_TARGET=BRANCH_TARGET (latest redirect wins); stays in DRAIN unless the drain completes this cycle, in which case FETCH_PC=BRANCH_TARGET and FSM->FETCH.
- DRAIN without FLUSH:
  - When IMEM_BUSYWAIT=0, the response is dropped, FETCH_PC=DRAIN_TARGET and FSM->FETCH.
  - VALID=0 throughout DRAIN.
- RESET has priority over FLUSH.
- The FIFO holds PC per entry, so PC at the output always matches INSTRUCTION, including across a stall or wrap.

Test Plan:
1. Reset with DEPTH=4, zero-wait memory returning addr+0x100, STALL=0 -> from cycle 2, VALID=1 and PC=0,4,8,... each cycle, with INSTRUCTION=PC+0x100.
2. STALL=1 held for 8 cycles -> COUNT reaches 4 and IMEM_READ drops to 0. Head holds PC=0. On release, PCs 0,4,8,12,16 are issued in order with no gap or duplicate.
3. Memory busywait of 3 cycles per access -> IMEM_ADDRESS is stable during BUSYWAIT=1, and one instruction is pushed per 4 cycles.
4. FLUSH with BRANCH_TARGET=0x203 and zero-wait memory, FIFO holding 3 entries -> next cycle VALID=0. The following fetch uses address 0x200, and the first VALID head has PC=0x200.
5. FLUSH (target 0x400) during BUSYWAIT=1 at address 0x10, then a second FLUSH (target 0x800) still in DRAIN -> the 0x10 response is dropped, the next IMEM_ADDRESS is 0x800, and no 0x400 or 0x10 entry is ever VALID.
6. RESET_PC=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. RESET asserted mid-busywait -> VALID=0 and IMEM_ADDRESS=RESET_PC next cycle.
